stream_slot_scheduler: RTL
==========================

# stream_slot_scheduler

Time-slot scheduler that shares one 16-bit output stream among N input data streams, granting each enabled stream a programmable slot in round-robin order. It generalises the two-stream fixed-period switching in the multiplexing datapath to N streams with per-stream slot lengths, valid/ready handshakes and run-time reconfiguration. It sits between the stream sources and the downstream symbol-rate consumer, in the `clk` domain.

## Interface
- `DW`, 16, data width per stream
- `N`, 4, number of input streams (2..8)
- `CW`, 32, slot-length counter width

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_load`  in  1  one-cycle pulse; captures `cfg_*` into pending config
- `cfg_mode`  in  1  0 = time slots (count clock cycles), 1 = beat slots (count accepted beats)
- `cfg_mask`  in  N  stream enable mask
- `cfg_slot`  in  N*CW  slot length per stream, stream i at bits [i*CW +: CW]
- `ds_data`  in  N*DW  stream data, stream i at bits [i*DW +: DW]
- `ds_valid`  in  N  per-stream valid
- `ds_ready`  out  N  per-stream ready
- `out_data`  out  DW  selected stream data
- `out_valid`  out  1  selected stream valid
- `out_ready`  in  1  downstream ready
- `cur_sel`  out  $clog2(N)  index of stream owning current slot
- `slot_start`  out  1  high on first cycle of every slot

## Operation
- Config: `cfg_load` writes pending register; pending copied to active at next slot boundary, or on the next edge when in IDLE. Multiple loads before a boundary: last wins. Load coincident with a boundary: new config governs the choice of next stream.
- Slot length 0 treated as 1.
- States: IDLE, SLOT (GUARD with macro).
- IDLE: `out_valid`=0, `ds_ready`=0. Moves to SLOT when active mask is nonzero, selecting lowest-index enabled stream.
- SLOT: slot counter starts at 1. Mode 0: increments every cycle. Mode 1: increments on each accepted beat (`out_valid & out_ready`). Slot ends on the cycle the counter equals slot length (mode 1: on the accepting cycle).
- Boundary: next stream = next enabled index above `cur_sel`, wrapping to 0; if only the current stream is enabled it is re-granted (new slot, `slot_start` again). Active mask all zero -> IDLE.
- Datapath is combinational: `out_data`=`ds_data[cur_sel]`, `out_valid`=`ds_valid[cur_sel]` in SLOT, `ds_ready[i]`=`out_ready` only for i=`cur_sel` in SLOT, else 0.
- Mode 1 with a silent stream holds its slot indefinitely (by design).

## Timing
- Reset values: state IDLE, `cur_sel`=0, counter=0, `slot_start`=0, `out_valid`=0, `ds_ready`=0, `out_data`=`ds_data[0]`; active and pending config: mode 0, mask 0, all slots 1.
- `cfg_load` at edge t in IDLE: active config valid after t+1; SLOT entered at t+2 with `slot_start`=1.
- Mode 0 slot length L: stream owns exactly L consecutive cycles; next slot starts the following cycle (no gap without macro).
- Data latency 0 cycles; control (`cur_sel`, `slot_start`) registered.
- `rst` mid-slot: next edge returns to reset values; pending config discarded.

## Configuration
- `STREAM_GUARD_CYCLE_EN` defined: one GUARD cycle inserted after every slot end (including re-grant); during GUARD `out_valid`=0, `ds_ready`=0, `cur_sel` already shows next stream, active config updated here; `slot_start` fires on the following SLOT cycle. Mask zero in GUARD -> IDLE.
- Not defined: no GUARD state; back-to-back slots.

## Structure
- Package `stream_mux_pkg`: state enum, mode constants (`MODE_TIME`, `MODE_BEAT`), default `DW`/`N`/`CW`, config struct (mode, mask, slots).
- Sub-module `next_stream_pick`: combinational rotating find-next-set-bit over mask from `cur_sel`, returns index and found flag.

## Test plan
- Reset, then load mode 0, mask 4'b0011, slots {3,2} -> from t+2: `cur_sel` 0 for 3 cycles, 1 for 2, repeat; `slot_start` every 3/2 cycles.
- Mode 1, mask 4'b0101, slot0=2, slot2=1, `out_ready` toggling 1,0 -> stream 0 slot ends on 2nd accepted beat, then stream 2 for 1 beat; `ds_ready` only on owner.
- Mid-slot load mask 4'b1000 while stream 0 holds slot length 5 -> stream 0 completes 5 cycles, then `cur_sel`=3.
- Load mask 0 during SLOT -> IDLE after current slot, `out_valid`=0, all `ds_ready`=0.
- Single enabled stream 1, slot 0 -> `cur_sel`=1 constant, `slot_start` high every cycle.
- With `STREAM_GUARD_CYCLE_EN`, mask 4'b0011, slots {2,2} -> pattern 0,0,G,1,1,G with `out_valid`=0 on G cycles; `rst` pulse mid-slot -> IDLE next edge.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream slot scheduler.
// STREAM_GUARD_CYCLE_EN adds a GUARD state between slots.
package stream_mux_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_N  = 4;
    localparam int DEF_CW = 32;

    // Slot accounting modes
    localparam logic MODE_TIME = 1'b0;  // slot counts clock cycles
    localparam logic MODE_BEAT = 1'b1;  // slot counts accepted beats

`ifdef STREAM_GUARD_CYCLE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT  = 2'd1,
        ST_GUARD = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT  = 2'd1
    } state_e;
`endif

    // Configuration at the default geometry
    typedef struct packed {
        logic                             mode;
        logic [DEF_N-1:0]                 mask;
        logic [DEF_N-1:0][DEF_CW-1:0]     slots;
    } cfg_t;

endpackage

// File: rtl/next_stream_pick.sv
// Rotating find-next-set-bit: first set bit of mask strictly above 'from',
// wrapping; returns 'from' itself when it is the only set bit.
module next_stream_pick #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] from,
    output logic [SW-1:0] idx,
    output logic          found
);

    logic [SW-1:0] cand;

    // Scan farthest-first so the nearest enabled stream wins
    always_comb begin
        idx   = from;
        found = |mask;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = SW'((int'(from) + k) % N);
            if (mask[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/stream_slot_scheduler.sv
// Round-robin time-slot scheduler sharing one output stream among N inputs.
// Optional: STREAM_GUARD_CYCLE_EN inserts one idle GUARD cycle after each slot.
module stream_slot_scheduler
    import stream_mux_pkg::*;
#(
    parameter  int DW = DEF_DW,
    parameter  int N  = DEF_N,
    parameter  int CW = DEF_CW,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_load,
    input  logic            cfg_mode,
    input  logic [N-1:0]    cfg_mask,
    input  logic [N*CW-1:0] cfg_slot,
    input  logic [N*DW-1:0] ds_data,
    input  logic [N-1:0]    ds_valid,
    output logic [N-1:0]    ds_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   cur_sel,
    output logic            slot_start
);

    // Same fields as cfg_t, sized by this instance's parameters
    typedef struct packed {
        logic                 mode;
        logic [N-1:0]         mask;
        logic [N-1:0][CW-1:0] slots;
    } act_cfg_t;

    function automatic act_cfg_t cfg_reset_val();
        act_cfg_t c;
        c.mode = MODE_TIME;
        c.mask = '0;
        for (int i = 0; i < N; i++) c.slots[i] = CW'(1);
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [SW-1:0]       cur_sel_q, cur_sel_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                slot_start_q, slot_start_d;
    act_cfg_t            act_q, act_d;
    act_cfg_t            pend_q, pend_d;
    act_cfg_t            cfg_in;

    logic [N-1:0][DW-1:0] ds_data_a;
    logic [CW-1:0]        slot_len, len_eff;
    logic                 beat, slot_end;
    logic [N-1:0]         pick_mask;
    logic [SW-1:0]        pick_from, pick_idx;
    logic                 pick_found;

    assign ds_data_a = ds_data;

    // Pending config follows the latest load; doubles as the config seen at a boundary
    always_comb begin
        cfg_in.mode  = cfg_mode;
        cfg_in.mask  = cfg_mask;
        cfg_in.slots = cfg_slot;
        pend_d       = cfg_load ? cfg_in : pend_q;
    end

    // Slot completion: a zero length behaves as one
    always_comb begin
        slot_len = act_q.slots[cur_sel_q];
        len_eff  = (slot_len == '0) ? CW'(1) : slot_len;
        beat     = out_valid & out_ready;
        slot_end = (state_q == ST_SLOT) && (cnt_q == len_eff) &&
                   ((act_q.mode == MODE_TIME) || beat);
    end

    // From IDLE search from the top so the lowest enabled stream is found
    always_comb begin
        pick_from = (state_q == ST_IDLE) ? SW'(N - 1) : cur_sel_q;
        pick_mask = (state_q == ST_IDLE) ? act_q.mask : pend_d.mask;
    end

    next_stream_pick #(.N(N)) u_pick (
        .mask  (pick_mask),
        .from  (pick_from),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Next-state: slot sequencing and active-config hand-over
    always_comb begin
        state_d      = state_q;
        cur_sel_d    = cur_sel_q;
        cnt_d        = cnt_q;
        slot_start_d = 1'b0;
        act_d        = act_q;
        case (state_q)
            ST_IDLE: begin
                act_d = pend_q;
                if (act_q.mask != '0) begin
                    state_d      = ST_SLOT;
                    cur_sel_d    = pick_idx;
                    cnt_d        = CW'(1);
                    slot_start_d = 1'b1;
                end
            end
            ST_SLOT: begin
                if (slot_end) begin
`ifdef STREAM_GUARD_CYCLE_EN
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    if (pick_found) cur_sel_d = pick_idx;
`else
                    act_d = pend_d;
                    if (pick_found) begin
                        cur_sel_d    = pick_idx;
                        cnt_d        = CW'(1);
                        slot_start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
`endif
                end else if ((act_q.mode == MODE_TIME) || beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef STREAM_GUARD_CYCLE_EN
            ST_GUARD: begin
                act_d = pend_d;
                if (pend_d.mask == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_SLOT;
                    cnt_d        = CW'(1);
                    slot_start_d = 1'b1;
                    // a load during GUARD may have disabled the chosen stream
                    if (!pend_d.mask[cur_sel_q]) cur_sel_d = pick_idx;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_sel_q    <= '0;
            cnt_q        <= '0;
            slot_start_q <= 1'b0;
            act_q        <= cfg_reset_val();
            pend_q       <= cfg_reset_val();
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            cnt_q        <= cnt_d;
            slot_start_q <= slot_start_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
        end
    end

    // Zero-latency datapath steered by the registered owner
    always_comb begin
        out_data  = ds_data_a[cur_sel_q];
        out_valid = (state_q == ST_SLOT) & ds_valid[cur_sel_q];
        ds_ready  = '0;
        if (state_q == ST_SLOT) ds_ready[cur_sel_q] = out_ready;
    end

    assign cur_sel    = cur_sel_q;
    assign slot_start = slot_start_q;

endmodule
